// File: rtl/reg_file_rename_pkg.sv
// Shared widths, the "no rename" tag value and the read-port result type
// for the architectural register file with rename tags.
package reg_file_rename_pkg;

    localparam int REG_COUNT  = 32;
    localparam int DATA_WIDTH = 32;
    localparam int TAG_WIDTH  = 5;
    localparam int IDX_WIDTH  = 5;

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [TAG_WIDTH-1:0]  tag_t;
    typedef logic [IDX_WIDTH-1:0]  idx_t;

    // Bit 4 set marks a register whose value is architectural (no pending producer).
    localparam tag_t NO_RENAME = tag_t'(16);

    // Result of one combinational operand lookup.
    typedef struct packed {
        data_t value;
        tag_t  rename;
    } rd_port_t;

    // x0 is hardwired: it is never written and never renamed.
    function automatic logic is_writable(input idx_t idx);
        return idx != '0;
    endfunction

endpackage

// File: rtl/reg_file_rename_if.sv
// Decoder/ROB side bundle of the rename register file: global ready, flush,
// ROB commit stream, decoder issue and the two operand lookup ports.
interface reg_file_rename_if;
    import reg_file_rename_pkg::*;

    logic  rdy;
    logic  flush;

    logic  commit_enable;
    idx_t  commit_rd;
    data_t commit_value;
    tag_t  commit_rename;

    logic  issue_enable;
    idx_t  issue_rd;
    tag_t  issue_rename;

    idx_t  rs1_index;
    idx_t  rs2_index;
    data_t rs1_value;
    tag_t  rs1_rename;
    data_t rs2_value;
    tag_t  rs2_rename;

    // Pipeline side: drives commit/issue/lookups, receives operands.
    modport master (
        output rdy, flush,
        output commit_enable, commit_rd, commit_value, commit_rename,
        output issue_enable, issue_rd, issue_rename,
        output rs1_index, rs2_index,
        input  rs1_value, rs1_rename, rs2_value, rs2_rename
    );

    // Register file side.
    modport slave (
        input  rdy, flush,
        input  commit_enable, commit_rd, commit_value, commit_rename,
        input  issue_enable, issue_rd, issue_rename,
        input  rs1_index, rs2_index,
        output rs1_value, rs1_rename, rs2_value, rs2_rename
    );

endinterface

// File: rtl/reg_file_rename.sv
// Architectural register file with per-register rename tags.
// Commit writes values and retires matching tags, issue installs new tags,
// flush drops every tag. Operand reads are combinational with commit bypass.
module reg_file_rename
    import reg_file_rename_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    reg_file_rename_if.slave  bus
);

    data_t r_value [REG_COUNT];
    tag_t  r_tag   [REG_COUNT];

    logic  w_commit_wr;
    logic  w_commit_retire;
    logic  w_issue_wr;

    assign w_commit_wr     = bus.commit_enable && is_writable(bus.commit_rd);
    assign w_commit_retire = w_commit_wr && (r_tag[bus.commit_rd] == bus.commit_rename);
    // Flush squashes the instruction being issued in the same cycle.
    assign w_issue_wr      = bus.issue_enable && is_writable(bus.issue_rd) && !bus.flush;

    // Value store: only the ROB commit stream writes architectural values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_value[i] <= '0;
            end
        end else if (bus.rdy && w_commit_wr) begin
            r_value[bus.commit_rd] <= bus.commit_value;
        end
    end

    // Tag store: issue placed after the commit clear so a same-cycle issue wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_tag[i] <= NO_RENAME;
            end
        end else if (bus.rdy) begin
            if (bus.flush) begin
                for (int i = 0; i < REG_COUNT; i++) begin
                    r_tag[i] <= NO_RENAME;
                end
            end else begin
                if (w_commit_retire) begin
                    r_tag[bus.commit_rd] <= NO_RENAME;
                end
                if (w_issue_wr) begin
                    r_tag[bus.issue_rd] <= bus.issue_rename;
                end
            end
        end
    end

    idx_t w_rs_idx [2];

    assign w_rs_idx[0] = bus.rs1_index;
    assign w_rs_idx[1] = bus.rs2_index;

    for (genvar p = 0; p < 2; p++) begin : g_rd
        rd_port_t w_rd;
        logic     w_bypass;

        // A value committing this cycle by the producer the register waits on is
        // forwarded immediately; a same-cycle issue is deliberately not visible.
        assign w_bypass = bus.commit_enable
                       && (bus.commit_rd == w_rs_idx[p])
                       && is_writable(w_rs_idx[p])
                       && (r_tag[w_rs_idx[p]] == bus.commit_rename);

        // Operand lookup with x0 forced and commit bypass.
        always_comb begin
            w_rd.value  = r_value[w_rs_idx[p]];
            w_rd.rename = r_tag[w_rs_idx[p]];
            if (!is_writable(w_rs_idx[p])) begin
                w_rd.value  = '0;
                w_rd.rename = NO_RENAME;
            end else if (w_bypass) begin
                w_rd.value  = bus.commit_value;
                w_rd.rename = NO_RENAME;
            end
        end
    end

    assign bus.rs1_value  = g_rd[0].w_rd.value;
    assign bus.rs1_rename = g_rd[0].w_rd.rename;
    assign bus.rs2_value  = g_rd[1].w_rd.value;
    assign bus.rs2_rename = g_rd[1].w_rd.rename;

endmodule

// File: tb/tb_reg_file_rename.sv
// Scoreboard bench for reg_file_rename: directed scenarios then random traffic,
// expected operands from a plain array model of the register file.
`timescale 1ns/1ps
module tb_reg_file_rename;

    logic clk;
    logic rst;

    reg_file_rename_if u_if ();

    reg_file_rename dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rdy;
        bit          flush;
        bit          ce;
        logic [4:0]  crd;
        logic [31:0] cv;
        logic [4:0]  crn;
        bit          ie;
        logic [4:0]  ird;
        logic [4:0]  irn;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } stim_t;

    typedef struct {
        logic [31:0] v1;
        logic [4:0]  t1;
        logic [31:0] v2;
        logic [4:0]  t2;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    logic [31:0] m_val [32];
    logic [4:0]  m_tag [32];

    localparam logic [4:0] NR = 5'd16;

    function automatic stim_t idle(input logic [4:0] a, input logic [4:0] b);
        stim_t s;
        s.rdy = 1; s.flush = 0; s.ce = 0; s.crd = 0; s.cv = 0; s.crn = 0;
        s.ie = 0; s.ird = 0; s.irn = 0; s.rs1 = a; s.rs2 = b;
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_val[i] = 32'd0;
            m_tag[i] = NR;
        end
    endtask

    // What the decoder should see for register r given this cycle's commit.
    task automatic model_read(input stim_t s, input logic [4:0] r,
                              output logic [31:0] v, output logic [4:0] t);
        if (r == 0) begin
            v = 0; t = NR;
        end else if (s.ce && s.crd == r && m_tag[r] == s.crn) begin
            v = s.cv; t = NR;
        end else begin
            v = m_val[r]; t = m_tag[r];
        end
    endtask

    // Architectural effect of one clock edge.
    task automatic model_step(input stim_t s);
        logic [4:0] nt [32];
        if (!s.rdy) return;
        for (int i = 0; i < 32; i++) nt[i] = m_tag[i];
        if (s.ce && s.crd != 0) begin
            m_val[s.crd] = s.cv;
            if (m_tag[s.crd] == s.crn) nt[s.crd] = NR;
        end
        if (s.flush) begin
            for (int i = 0; i < 32; i++) nt[i] = NR;
        end else if (s.ie && s.ird != 0) begin
            nt[s.ird] = s.irn;
        end
        for (int i = 0; i < 32; i++) m_tag[i] = nt[i];
    endtask

    task automatic apply(input stim_t s);
        u_if.rdy           = s.rdy;
        u_if.flush         = s.flush;
        u_if.commit_enable = s.ce;
        u_if.commit_rd     = s.crd;
        u_if.commit_value  = s.cv;
        u_if.commit_rename = s.crn;
        u_if.issue_enable  = s.ie;
        u_if.issue_rd      = s.ird;
        u_if.issue_rename  = s.irn;
        u_if.rs1_index     = s.rs1;
        u_if.rs2_index     = s.rs2;
    endtask

    task automatic push_exp(input stim_t s, input string name);
        exp_t e;
        model_read(s, s.rs1, e.v1, e.t1);
        model_read(s, s.rs2, e.v2, e.t2);
        e.name = name;
        exp_q.push_back(e);
    endtask

    // One clocked transaction: drive after the edge, expect this cycle's reads.
    task automatic drive(input stim_t s, input string name);
        @(posedge clk);
        #1;
        apply(s);
        push_exp(s, name);
        model_step(s);
    endtask

    // Asynchronous reset raised between edges; reads must clear before the next edge.
    task automatic reset_mid(input logic [4:0] a, input logic [4:0] b);
        stim_t s;
        s = idle(a, b);
        @(posedge clk);
        #1;
        apply(s);
        #1;
        rst = 1'b1;
        model_reset();
        push_exp(s, "async_reset");
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic cmp32(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, want);
        end
    endtask

    task automatic cmp5(input string name, input logic [4:0] got, input logic [4:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Monitor: compare outputs mid-cycle against the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp32({e.name, ".rs1_value"},  u_if.rs1_value,  e.v1);
            cmp5 ({e.name, ".rs1_rename"}, u_if.rs1_rename, e.t1);
            cmp32({e.name, ".rs2_value"},  u_if.rs2_value,  e.v2);
            cmp5 ({e.name, ".rs2_rename"}, u_if.rs2_rename, e.t2);
        end
    end

    initial begin
        stim_t s;
        rst = 1'b1;
        model_reset();
        s = idle(5, 0);
        apply(s);
        push_exp(s, "reset");
        @(negedge clk);
        #2;
        rst = 1'b0;

        // Rename then commit with bypass.
        s = idle(0, 0); s.ie = 1; s.ird = 5; s.irn = 3;
        drive(s, "issue5");
        drive(idle(5, 0), "read5_renamed");
        s = idle(5, 5); s.ce = 1; s.crd = 5; s.crn = 3; s.cv = 32'hDEADBEEF;
        drive(s, "commit5_bypass");
        drive(idle(5, 0), "read5_committed");

        // Older producer commits while a younger one is pending.
        s = idle(0, 0); s.ie = 1; s.ird = 7; s.irn = 2;
        drive(s, "issue7a");
        s = idle(7, 0); s.ie = 1; s.ird = 7; s.irn = 9;
        drive(s, "issue7b");
        s = idle(7, 7); s.ce = 1; s.crd = 7; s.crn = 2; s.cv = 32'h11;
        drive(s, "commit7_old");
        drive(idle(7, 0), "read7");

        // Same-cycle commit and issue to one register.
        s = idle(0, 0); s.ie = 1; s.ird = 4; s.irn = 1;
        drive(s, "issue4");
        s = idle(4, 0); s.ce = 1; s.crd = 4; s.crn = 1; s.cv = 32'h22;
        s.ie = 1; s.ird = 4; s.irn = 6;
        drive(s, "commit_issue4");
        drive(idle(4, 0), "read4");

        // Flush with concurrent issue and commit.
        s = idle(0, 0); s.ie = 1; s.ird = 3;  s.irn = 11; drive(s, "issue3");
        s = idle(0, 0); s.ie = 1; s.ird = 8;  s.irn = 12; drive(s, "issue8");
        s = idle(3, 8); s.ie = 1; s.ird = 12; s.irn = 13; drive(s, "issue12");
        s = idle(12, 10); s.flush = 1; s.ie = 1; s.ird = 10; s.irn = 5;
        s.ce = 1; s.crd = 3; s.crn = 0; s.cv = 32'h33;
        drive(s, "flush");
        drive(idle(3, 10), "post_flush_a");
        drive(idle(8, 12), "post_flush_b");

        // x0 write attempts and a stalled commit.
        s = idle(0, 0); s.ce = 1; s.crd = 0; s.cv = 32'hFF; s.crn = 16;
        s.ie = 1; s.ird = 0; s.irn = 2;
        drive(s, "x0_write");
        drive(idle(0, 0), "x0_read");
        s = idle(6, 0); s.rdy = 0; s.ce = 1; s.crd = 6; s.crn = 7; s.cv = 32'h66;
        s.ie = 1; s.ird = 9; s.irn = 4;
        drive(s, "stall_commit6");
        drive(idle(6, 9), "read6_after_stall");

        reset_mid(5, 4);
        drive(idle(7, 3), "after_reset");

        // Random traffic, with a commit tag often matching the live mapping.
        for (int n = 0; n < 1500; n++) begin
            s = idle(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            s.rdy   = ($urandom_range(0, 7) != 0);
            s.flush = ($urandom_range(0, 15) == 0);
            s.ce    = $urandom_range(0, 1);
            s.crd   = 5'($urandom_range(0, 7));
            s.cv    = $urandom;
            s.crn   = ($urandom_range(0, 1) == 1) ? m_tag[s.crd] : 5'($urandom_range(0, 31));
            s.ie    = $urandom_range(0, 1);
            s.ird   = 5'($urandom_range(0, 7));
            s.irn   = 5'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) s.rs1 = s.crd;
            if ($urandom_range(0, 3) == 0) s.rs2 = s.ird;
            drive(s, "random");
            if (n == 700) reset_mid(s.crd, s.ird);
        end

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
